// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the debug-assistant serial link.
// The same constants are used by both the receive and transmit ends.
package uart_pkg;

  localparam int BAUD           = 256000;
  localparam int SYS_CLK_PERIOD = 50;
  localparam int BIT_CYCLES     = 1_000_000_000 / BAUD / SYS_CLK_PERIOD;
  localparam logic [7:0] CMD    = 8'h01;
  localparam int TIMEOUT_BITS   = 20;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    FR_H0,
    FR_H1,
    FR_D0,
    FR_D1,
    FR_T0,
    FR_T1
  } frame_state_e;

endpackage

// File: rtl/uart_rxd_byte.sv
// 8N1 byte receiver: RXD synchroniser, falling-edge start detection and
// mid-bit sampling. Emits one-cycle byte_valid / byte_err pulses.
module uart_rxd_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = BIT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic        sync1_q, sync2_q, sync3_q;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        line;
  logic        fall;

  assign line = sync2_q;
  assign fall = sync3_q & ~sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!line) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {line, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        // After a framing error, wait for the line to recover before re-arming.
        if (hold_q) begin
          if (line) begin
            hold_d  = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (line) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            err_d  = 1'b1;
            hold_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sync3_q   <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      hold_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/uart_rxd_frame.sv
// Frame parser for CMD, ~CMD, P0, P1, ~CMD, CMD with an inter-byte timeout;
// accepted payloads are written as two back-to-back FIFO words.
module uart_rxd_frame
  import uart_pkg::*;
(
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       RXD,
  input  logic       WRFULL,
  output logic       WRCLK,
  output logic       WRREQ,
  output logic [7:0] DATA_OUT,
  output logic       FRAME_OK,
  output logic       FRAME_ERR
);

  localparam logic [7:0]  NCMD        = ~CMD;
  localparam logic [15:0] BIT_LAST    = 16'(BIT_CYCLES - 1);
  localparam logic [4:0]  TIMEOUT_LIM = 5'(TIMEOUT_BITS);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;

  uart_rxd_byte #(.CLKS_PER_BIT(BIT_CYCLES)) u_byte (
    .clk        (SYS_CLK),
    .rst_n      (RST_N),
    .rxd        (RXD),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err)
  );

  frame_state_e fr_state_q, fr_state_d;
  logic [7:0]   p0_q, p0_d, p1_q, p1_d;
  logic [15:0]  gap_cnt_q, gap_cnt_d;
  logic [4:0]   gap_bits_q, gap_bits_d;
  logic         wr_second_q, wr_second_d;
  logic         wrreq_q, wrreq_d;
  logic [7:0]   data_q, data_d;
  logic         ok_q, ok_d;
  logic         err_q, err_d;

  always_comb begin
    fr_state_d  = fr_state_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    gap_cnt_d   = gap_cnt_q;
    gap_bits_d  = gap_bits_q;
    wr_second_d = 1'b0;
    wrreq_d     = 1'b0;
    data_d      = data_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;

    // Gap timer counts whole bit times since the last good byte inside a frame.
    if (fr_state_q == FR_H0 || byte_valid) begin
      gap_cnt_d  = '0;
      gap_bits_d = '0;
    end else if (gap_cnt_q == BIT_LAST) begin
      gap_cnt_d  = '0;
      gap_bits_d = gap_bits_q + 5'd1;
    end else begin
      gap_cnt_d = gap_cnt_q + 16'd1;
    end

    if (wr_second_q) begin
      wrreq_d = 1'b1;
      data_d  = p1_q;
    end

    if (byte_err) begin
      if (fr_state_q != FR_H0) begin
        err_d      = 1'b1;
        fr_state_d = FR_H0;
      end
    end else if (byte_valid) begin
      case (fr_state_q)
        FR_H0: if (byte_data == CMD) fr_state_d = FR_H1;
        FR_H1: begin
          if (byte_data == NCMD) begin
            fr_state_d = FR_D0;
          end else if (byte_data != CMD) begin
            err_d      = 1'b1;
            fr_state_d = FR_H0;
          end
        end
        FR_D0: begin
          p0_d       = byte_data;
          fr_state_d = FR_D1;
        end
        FR_D1: begin
          p1_d       = byte_data;
          fr_state_d = FR_T0;
        end
        FR_T0: begin
          if (byte_data == NCMD) begin
            fr_state_d = FR_T1;
          end else begin
            err_d      = 1'b1;
            fr_state_d = (byte_data == CMD) ? FR_H1 : FR_H0;
          end
        end
        FR_T1: begin
          fr_state_d = FR_H0;
          if (byte_data != CMD || WRFULL) begin
            err_d = 1'b1;
          end else begin
            wrreq_d     = 1'b1;
            data_d      = p0_q;
            ok_d        = 1'b1;
            wr_second_d = 1'b1;
          end
        end
        default: fr_state_d = FR_H0;
      endcase
    end else if (fr_state_q != FR_H0 && gap_bits_q == TIMEOUT_LIM) begin
      err_d      = 1'b1;
      fr_state_d = FR_H0;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      fr_state_q  <= FR_H0;
      p0_q        <= '0;
      p1_q        <= '0;
      gap_cnt_q   <= '0;
      gap_bits_q  <= '0;
      wr_second_q <= 1'b0;
      wrreq_q     <= 1'b0;
      data_q      <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fr_state_q  <= fr_state_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_bits_q  <= gap_bits_d;
      wr_second_q <= wr_second_d;
      wrreq_q     <= wrreq_d;
      data_q      <= data_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  assign WRCLK     = ~SYS_CLK;
  assign WRREQ     = wrreq_q;
  assign DATA_OUT  = data_q;
  assign FRAME_OK  = ok_q;
  assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_uart_rxd_frame.sv
// Directed and randomized frames driven bit-serially on RXD; FIFO writes and
// frame pulses are collected and compared against frame-level expectations.
module tb_uart_rxd_frame;

  localparam int BIT_CLKS = 1_000_000_000 / 256000 / 50;
  localparam logic [7:0] C_CMD  = 8'h01;
  localparam logic [7:0] C_NCMD = 8'hFE;

  logic       SYS_CLK = 1'b0;
  logic       RST_N   = 1'b0;
  logic       RXD     = 1'b1;
  logic       WRFULL  = 1'b0;
  logic       WRCLK;
  logic       WRREQ;
  logic [7:0] DATA_OUT;
  logic       FRAME_OK;
  logic       FRAME_ERR;

  uart_rxd_frame dut (
    .SYS_CLK   (SYS_CLK),
    .RST_N     (RST_N),
    .RXD       (RXD),
    .WRFULL    (WRFULL),
    .WRCLK     (WRCLK),
    .WRREQ     (WRREQ),
    .DATA_OUT  (DATA_OUT),
    .FRAME_OK  (FRAME_OK),
    .FRAME_ERR (FRAME_ERR)
  );

  // Clock and cycle counter
  always #25 SYS_CLK = ~SYS_CLK;
  int cyc = 0;
  always @(posedge SYS_CLK) cyc <= cyc + 1;

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int exp_ok = 0, exp_err = 0;
  int ok_cnt = 0, err_cnt = 0;
  int bad_burst = 0, ok_no_wr = 0, wr_run = 0;
  int last_err_cyc = 0;

  // Output monitor
  always @(negedge SYS_CLK) begin
    if (RST_N) begin
      if (WRREQ) begin
        got_q.push_back(DATA_OUT);
        wr_run = wr_run + 1;
      end else if (wr_run != 0) begin
        if (wr_run != 2) bad_burst = bad_burst + 1;
        wr_run = 0;
      end
      if (FRAME_OK) begin
        ok_cnt = ok_cnt + 1;
        if (!WRREQ) ok_no_wr = ok_no_wr + 1;
      end
      if (FRAME_ERR) begin
        err_cnt = err_cnt + 1;
        last_err_cyc = cyc;
      end
    end else begin
      wr_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
    RXD = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      wait_clks(BIT_CLKS);
    end
    RXD = stop_bit;
    wait_clks(BIT_CLKS);
    RXD = 1'b1;
    wait_clks(gap * BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1, input int gap);
    send_byte(C_CMD, 1'b1, gap);
    send_byte(C_NCMD, 1'b1, gap);
    send_byte(p0, 1'b1, gap);
    send_byte(p1, 1'b1, gap);
    send_byte(C_NCMD, 1'b1, gap);
    send_byte(C_CMD, 1'b1, gap);
  endtask

  task automatic check_stream(input string tag);
    int n;
    wait_clks(2 * BIT_CLKS);
    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check({tag, "_frame_ok"}, ok_cnt, exp_ok);
    check({tag, "_frame_err"}, err_cnt, exp_err);
  endtask

  initial begin
    int t77;
    logic [7:0] p0, p1, x;
    logic full;

    // Reset state
    RST_N = 1'b0;
    wait_clks(3);
    check("rst_wrreq", WRREQ, 0);
    check("rst_data", DATA_OUT, 0);
    check("rst_ok", FRAME_OK, 0);
    check("rst_err", FRAME_ERR, 0);
    check("wrclk_low_phase", WRCLK, 1);
    @(posedge SYS_CLK);
    #1;
    check("wrclk_high_phase", WRCLK, 0);
    wait_clks(2);
    RST_N = 1'b1;
    wait_clks(2 * BIT_CLKS);

    // Basic frame
    send_frame(8'h5A, 8'hA5, 1);
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5); exp_ok++;
    check_stream("basic");

    // Short low glitch on idle line
    RXD = 1'b0;
    wait_clks(20);
    RXD = 1'b1;
    check_stream("glitch");

    // Bad stop bit on 4th byte, then a clean frame
    send_byte(C_CMD, 1'b1, 1);
    send_byte(C_NCMD, 1'b1, 1);
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b0, 1);
    send_byte(C_NCMD, 1'b1, 1);
    send_byte(C_CMD, 1'b1, 1);
    exp_err++;
    send_frame(8'h12, 8'h34, 1);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_ok++;
    check_stream("stop_err");

    // Repeated CMD resynchronises
    send_byte(C_CMD, 1'b1, 1);
    send_frame(8'h33, 8'h44, 1);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_ok++;
    check_stream("resync");

    // Inter-byte timeout after the first payload byte
    send_byte(C_CMD, 1'b1, 1);
    send_byte(C_NCMD, 1'b1, 1);
    t77 = cyc;
    send_byte(8'h77, 1'b1, 25);
    exp_err++;
    check("timeout_late", ((last_err_cyc - t77) >= 29 * BIT_CLKS), 1);
    check("timeout_early", ((last_err_cyc - t77) <= 30 * BIT_CLKS), 1);
    check_stream("timeout");

    // FIFO full at commit
    WRFULL = 1'b1;
    send_frame(8'h99, 8'h66, 1);
    WRFULL = 1'b0;
    exp_err++;
    check_stream("full");

    // Reset in the middle of the second payload byte
    send_byte(C_CMD, 1'b1, 1);
    send_byte(C_NCMD, 1'b1, 1);
    send_byte(8'hAB, 1'b1, 1);
    RXD = 1'b0;
    wait_clks(BIT_CLKS);
    RXD = 1'b1;
    wait_clks(30);
    RST_N = 1'b0;
    #1;
    check("midrst_wrreq", WRREQ, 0);
    check("midrst_data", DATA_OUT, 0);
    check("midrst_ok", FRAME_OK, 0);
    check("midrst_err", FRAME_ERR, 0);
    wait_clks(5);
    RST_N = 1'b1;
    wait_clks(2 * BIT_CLKS);
    send_frame(8'hC3, 8'h3C, 1);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C); exp_ok++;
    check_stream("after_rst");

    // Randomized segments with outcomes known by construction
    for (int s = 0; s < 6; s++) begin
      p0 = 8'($urandom_range(0, 255));
      p1 = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0, 1: begin
          full = ($urandom_range(0, 3) == 0);
          WRFULL = full;
          send_frame(p0, p1, $urandom_range(1, 2));
          WRFULL = 1'b0;
          if (full) exp_err++;
          else begin
            exp_q.push_back(p0); exp_q.push_back(p1); exp_ok++;
          end
        end
        2: begin
          x = 8'($urandom_range(2, 255));
          send_byte(x, 1'b1, $urandom_range(1, 2));
        end
        default: begin
          x = 8'($urandom_range(2, 253));
          send_byte(C_CMD, 1'b1, 1);
          send_byte(C_NCMD, 1'b1, 1);
          send_byte(p0, 1'b1, 1);
          send_byte(p1, 1'b1, 1);
          send_byte(x, 1'b1, 2);
          exp_err++;
        end
      endcase
    end
    check_stream("rand");

    check("burst_len", bad_burst, 0);
    check("ok_with_write", ok_no_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
